// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states and
// byte-lane helpers used by both the datapath and the control FSM.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} lsu_state_t;

    function automatic logic f3_legal(input logic wr, input logic [2:0] f3);
        if (wr)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // f3[1:0] encodes access size for every legal code: 00 byte, 01 half, 10 word
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    endfunction

    function automatic logic [1:0] align_lo(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b01:   return {a[1], 1'b0};
            2'b10:   return 2'b00;
            default: return a;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables / data replication and load
// lane extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] ld_word_i,
    output logic [3:0]  be_o,
    output logic [31:0] st_data_o,
    output logic [31:0] ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        be_o = store_be(funct3_i, addr_lo_i);
        case (funct3_i[1:0])
            2'b00:   st_data_o = {4{st_data_i[7:0]}};
            2'b01:   st_data_o = {2{st_data_i[15:0]}};
            default: st_data_o = st_data_i;
        endcase
    end

    always_comb begin
        case (addr_lo_i)
            2'b00:   ld_byte = ld_word_i[7:0];
            2'b01:   ld_byte = ld_word_i[15:8];
            2'b10:   ld_byte = ld_word_i[23:16];
            default: ld_byte = ld_word_i[31:24];
        endcase
        ld_half = addr_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
        case (funct3_i)
            F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data_o = {24'h0, ld_byte};
            F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data_o = {16'h0, ld_half};
            default: ld_data_o = ld_word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store stage between the MEM state and a synchronous data RAM.
// Optional LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int RAM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_re,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [2:0] CNT_LAST = 3'(RAM_LATENCY - 1);

    lsu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        lo_q, lo_d;
    logic [2:0]        f3_q, f3_d;
    logic              wr_q, wr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              acc_err;
    logic [3:0]        be;
    logic [31:0]       st_rep;
    logic [31:0]       ld_data;
    logic              unused_addr_hi;

    // Address bits above the RAM window wrap silently
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

`ifdef LSU_MISALIGN_TRAP_EN
    assign acc_err = !f3_legal(req_write, req_funct3) || is_misaligned(req_funct3, req_addr[1:0]);
`else
    assign acc_err = !f3_legal(req_write, req_funct3);
`endif

    lsu_align u_align (
        .funct3_i  (f3_q),
        .addr_lo_i (lo_q),
        .st_data_i (wdata_q),
        .ld_word_i (mem_rdata),
        .be_o      (be),
        .st_data_o (st_rep),
        .ld_data_o (ld_data)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lo_d    = lo_q;
        f3_d    = f3_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr[ADDR_W+1:2];
                    // Without the trap, low bits are forced to natural alignment
                    lo_d    = align_lo(req_funct3, req_addr[1:0]);
                    f3_d    = req_funct3;
                    wr_d    = req_write;
                    wdata_d = req_wdata;
                    err_d   = acc_err;
                    state_d = acc_err ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = wr_q ? RESP : WAIT;
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    rdata_d = ld_data;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            lo_q    <= '0;
            f3_q    <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lo_q    <= lo_d;
            f3_q    <= f3_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobes decode straight from state so an async reset kills them immediately
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = rdata_q;
    assign mem_re     = (state_q == ISSUE) & ~wr_q;
    assign mem_we     = (state_q == ISSUE) & wr_q;
    assign mem_be     = mem_we ? be : 4'b0000;
    assign mem_addr   = addr_q;
    assign mem_wdata  = st_rep;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench: a golden byte-level memory model predicts
// load results, strobes, latency and errors for every transaction.
module tb_load_store_unit;

    localparam int AW  = 9;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_write;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr, req_wdata;
    logic          req_ready, resp_valid, resp_err;
    logic [31:0]   resp_rdata;
    logic          mem_re, mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] ram   [0:511] = '{default: 32'h0};
    logic [31:0] rpipe [0:LAT-1] = '{default: 32'h0};
    logic [31:0] gm    [0:511];
    logic [31:0] rdata_model;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(AW), .DATA_W(32), .RAM_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_re(mem_re), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Synchronous RAM with LAT-cycle read latency
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= merge(ram[mem_addr], mem_wdata, mem_be);
        rpipe[0] <= mem_re ? ram[mem_addr] : 32'hBAD0BAD0;
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = rpipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic txn(input bit wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        bit          legal, mis, err, seen, rdy_bad;
        int          sz, n, off, widx, exp_lat, lat, nwe, nre;
        logic [31:0] ea, ew, sh, ev;
        logic [3:0]  ebe;
        legal = wr ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        sz    = int'(f3[1:0]);
        n     = 1 << sz;
        mis   = (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00);
        err   = !legal;
`ifdef LSU_MISALIGN_TRAP_EN
        err   = err || mis;
`endif
        ea = a;
        if (sz == 1) ea[0] = 1'b0;
        if (sz == 2) ea[1:0] = 2'b00;
        off  = int'(ea[1:0]);
        widx = int'(ea[10:2]);
        exp_lat = err ? 1 : (wr ? 2 : 2 + LAT);
        ebe = 4'(((1 << n) - 1) << off);
        ew  = (sz == 0) ? {4{wd[7:0]}} : (sz == 1) ? {2{wd[15:0]}} : wd;

        @(negedge clk);
        chk("ready_before", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        seen = 0; rdy_bad = 0; nwe = 0; nre = 0; lat = 0;
        for (int c = 1; c <= 30 && !seen; c++) begin
            @(negedge clk);
            // junk request while busy must be ignored
            req_valid = 1'($urandom); req_write = 1'($urandom); req_funct3 = 3'($urandom);
            req_addr = $urandom; req_wdata = $urandom;
            if (req_ready) rdy_bad = 1;
            if (mem_we) begin
                nwe++;
                chk("st_be", {28'b0, mem_be}, {28'b0, ebe});
                chk("st_addr", 32'(mem_addr), 32'(widx));
                chk("st_wdata", mem_wdata, ew);
            end
            if (mem_re) begin
                nre++;
                chk("ld_addr", 32'(mem_addr), 32'(widx));
            end
            if (resp_valid) begin
                seen = 1; lat = c;
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        if (!seen) begin
            chk("timeout", 32'd0, 32'd1);
            return;
        end
        if (!err && wr) begin
            ev = gm[widx];
            for (int k = 0; k < n; k++) ev[8*(off+k) +: 8] = wd[8*k +: 8];
            gm[widx] = ev;
        end
        if (!err && !wr) begin
            sh = gm[widx] >> (8 * off);
            if (n == 1)      rdata_model = f3[2] ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            else if (n == 2) rdata_model = f3[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            else             rdata_model = sh;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("ready_busy", {31'b0, rdy_bad}, 32'd0);
        chk("resp_err", {31'b0, resp_err}, {31'b0, err});
        chk("rdata", resp_rdata, rdata_model);
        chk("we_count", 32'(nwe), (!err && wr) ? 32'd1 : 32'd0);
        chk("re_count", 32'(nre), (!err && !wr) ? 32'd1 : 32'd0);
        @(negedge clk);
        chk("ready_after", {30'b0, req_ready, resp_valid}, 32'd2);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) gm[i] = 32'h0;
        rdata_model = 32'h0;
        rst = 1'b1;
        req_valid = 0; req_write = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_strobes", {28'b0, resp_valid, resp_err, mem_re, mem_we}, 32'd0);
        chk("rst_be_addr", {19'b0, mem_be, mem_addr}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        rst = 1'b0;

        txn(1, 3'b010, 32'h10, 32'hDEADBEEF);
        txn(1, 3'b000, 32'h13, 32'h000000A5);
        txn(0, 3'b100, 32'h13, 32'h0);
        chk("lbu_a5", resp_rdata, 32'h000000A5);
        txn(1, 3'b010, 32'h10, 32'h80FF0000);
        txn(0, 3'b000, 32'h13, 32'h0);
        chk("lb_sext", resp_rdata, 32'hFFFFFF80);
        txn(0, 3'b001, 32'h12, 32'h0);
        chk("lh_sext", resp_rdata, 32'hFFFF80FF);
        txn(0, 3'b101, 32'h12, 32'h0);
        chk("lhu_zext", resp_rdata, 32'h000080FF);
        txn(0, 3'b011, 32'h10, 32'h0);
        txn(1, 3'b100, 32'h10, 32'h12345678);
        txn(1, 3'b010, 32'h0, 32'hCAFEF00D);
        txn(0, 3'b010, 32'h02, 32'h0);
        txn(1, 3'b001, 32'h21, 32'hABCD1234);
        txn(0, 3'b010, 32'hFFFF_F010, 32'h0);

        // reset in the ISSUE cycle of a store must suppress the write
        @(negedge clk);
        req_valid = 1; req_write = 1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h5A5A1234;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        chk("rst_issue_we", {31'b0, mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_we_drop", {31'b0, mem_we}, 32'd0);
        chk("rst_ready_mid", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        rdata_model = 32'h0;
        chk("rst_ram_kept", ram[16], gm[16]);
        chk("rst_rdata_clr", resp_rdata, 32'd0);
        txn(0, 3'b010, 32'h40, 32'h0);

        for (int i = 0; i < 250; i++) begin
            logic [31:0] ra;
            ra = $urandom;
            ra[9:4] = 6'd0;
            txn(1'($urandom), 3'($urandom), ra, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
